cache_request_controller: RTL and testbench

- Upstream control stage for the cache/RAM memory datapath. Accepts single-word read requests from the CPU side through a ready/valid handshake.
- Drives the datapath's 15-bit word address and its cache-fill write enable. Checks the datapath hit flag and, on a miss, waits a fixed main-memory latency, then pulses a line fill.
- Returns the 32-bit word to the requester and keeps saturating hit/miss statistics.

---
 rtl/cache_request_controller.sv | 106 ++++++++++
 tb/tb_cache_request_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cache_request_controller.sv
// Request sequencer in front of the cache/RAM datapath: single-word reads,
// hit/miss lookup, fixed-latency miss wait, line fill, recheck and response.
module cache_request_controller #(
  parameter int MISS_LATENCY = 4,
  parameter int STAT_W       = 16
) (
  input  logic              globalclock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [14:0]       cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_was_hit,
  output logic [14:0]       dp_address,
  output logic              dp_wrEn,
  input  logic              dp_hit,
  input  logic [31:0]       dp_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
  output logic              fill_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_MISS_WAIT = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_RECHECK   = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [7:0] WAIT_INIT = 8'(MISS_LATENCY - 1);

  logic [2:0]        r_state;
  logic [7:0]        r_wait;
  logic [31:0]       r_rdata;
  logic              r_was_hit;
  logic [14:0]       r_addr;
  logic [STAT_W-1:0] r_hits;
  logic [STAT_W-1:0] r_misses;
  logic              r_fill_err;

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (&v) return v;
    return v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge globalclock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait     <= 8'd0;
      r_rdata    <= 32'd0;
      r_was_hit  <= 1'b0;
      r_addr     <= 15'd0;
      r_hits     <= '0;
      r_misses   <= '0;
      r_fill_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (dp_hit) begin
            r_rdata   <= dp_rdata;
            r_was_hit <= 1'b1;
            r_hits    <= sat_inc(r_hits);
            r_state   <= S_RESP;
          end else begin
            r_misses <= sat_inc(r_misses);
            r_wait   <= WAIT_INIT;
            r_state  <= S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (r_wait == 8'd0) r_state <= S_FILL;
          else                r_wait  <= r_wait - 8'd1;
        end
        S_FILL: r_state <= S_RECHECK;
        S_RECHECK: begin
          // The line was just written; a miss here means the fill did not take.
          r_rdata   <= dp_rdata;
          r_was_hit <= 1'b0;
          if (!dp_hit) r_fill_err <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready   = (r_state == S_IDLE);
  assign cpu_rvalid  = (r_state == S_RESP);
  assign dp_wrEn     = (r_state == S_FILL);
  assign cpu_rdata   = r_rdata;
  assign cpu_was_hit = r_was_hit;
  assign dp_address  = r_addr;
  assign hit_count   = r_hits;
  assign miss_count  = r_misses;
  assign fill_err    = r_fill_err;

endmodule

// File: tb/tb_cache_request_controller.sv
// Bench for cache_request_controller with a tiny datapath model whose hit
// flag and data change once the controller pulses the line fill.
module tb_cache_request_controller;

  localparam int LAT = 4;
  localparam int SW  = 4;

  logic          clk = 1'b0;
  logic          reset, cpu_req;
  logic [14:0]   cpu_addr;
  logic          cpu_ready, cpu_rvalid, cpu_was_hit, dp_wrEn, dp_hit, fill_err;
  logic [31:0]   cpu_rdata, dp_rdata;
  logic [14:0]   dp_address;
  logic [SW-1:0] hit_count, miss_count;

  // Datapath model
  logic        m_clear, m_filled, m_hit_before, m_hit_after;
  logic [31:0] m_hit_data, m_fill_data;
  always @(posedge clk) begin
    if (m_clear)      m_filled <= 1'b0;
    else if (dp_wrEn) m_filled <= 1'b1;
  end
  assign dp_hit   = m_filled ? m_hit_after : m_hit_before;
  assign dp_rdata = m_filled ? m_fill_data : m_hit_data;

  always #5 clk = ~clk;

  cache_request_controller #(.MISS_LATENCY(LAT), .STAT_W(SW)) dut (
    .globalclock(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_was_hit(cpu_was_hit), .dp_address(dp_address), .dp_wrEn(dp_wrEn),
    .dp_hit(dp_hit), .dp_rdata(dp_rdata), .hit_count(hit_count),
    .miss_count(miss_count), .fill_err(fill_err)
  );

  typedef struct {
    logic [14:0] addr;
    logic        hb;
    logic        ha;
    logic [31:0] hdata;
    logic [31:0] fdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    int          exp_lat;
    int          exp_fills;
    logic        exp_err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0]   sb[$];
  logic [SW-1:0] exp_hits, exp_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] sat(input logic [SW-1:0] v);
    return (v == SW'(15)) ? v : v + SW'(1);
  endfunction

  task automatic do_req(input vec_t v, input int idx);
    int cyc, rv_cyc, fills, fill_cyc, addr_bad;
    logic [14:0] fill_addr;
    logic [32:0] e;
    string tag;
    tag = $sformatf("v%0d", idx);
    m_hit_before = v.hb; m_hit_after = v.ha;
    m_hit_data = v.hdata; m_fill_data = v.fdata;
    m_clear = 1'b1; cpu_addr = v.addr; cpu_req = 1'b1;
    sb.push_back({v.exp_hit, v.exp_rdata});
    if (v.hb) exp_hits = sat(exp_hits); else exp_misses = sat(exp_misses);
    @(posedge clk); #1;
    cpu_req = 1'b0; m_clear = 1'b0; cpu_addr = ~v.addr;
    cyc = 1; rv_cyc = 0; fills = 0; fill_cyc = 0; fill_addr = '0; addr_bad = 0;
    while (rv_cyc == 0 && cyc < 40) begin
      if (dp_address !== v.addr) addr_bad++;
      if (dp_wrEn) begin fills++; fill_cyc = cyc; fill_addr = dp_address; end
      if (cpu_rvalid) rv_cyc = cyc;
      else begin @(posedge clk); #1; cyc++; end
    end
    chk({tag, "_lat"}, rv_cyc, v.exp_lat);
    if (rv_cyc != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, cpu_rdata, e[31:0]);
      chk({tag, "_was_hit"}, {31'd0, cpu_was_hit}, {31'd0, e[32]});
    end
    chk({tag, "_fills"}, fills, v.exp_fills);
    if (v.exp_fills > 0) begin
      chk({tag, "_fill_cyc"}, fill_cyc, v.exp_lat - 2);
      chk({tag, "_fill_addr"}, {17'd0, fill_addr}, {17'd0, v.addr});
    end
    chk({tag, "_addr_held"}, addr_bad, 0);
    chk({tag, "_hits"}, {28'd0, hit_count}, {28'd0, exp_hits});
    chk({tag, "_misses"}, {28'd0, miss_count}, {28'd0, exp_misses});
    chk({tag, "_fill_err"}, {31'd0, fill_err}, {31'd0, v.exp_err});
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, {31'd0, cpu_ready}, 32'd1);
    chk({tag, "_rvalid_pulse"}, {31'd0, cpu_rvalid}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int c, nrv, last_rv, bad_gap, bad_addr, bad_fill, bad_rv;
    logic [14:0] acc_addr;
    vecs[0] = '{15'h0123, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b1, 2,       0, 1'b0};
    vecs[1] = '{15'h0123, 1'b0, 1'b1, 32'h11111111, 32'h00C0FFEE, 32'h00C0FFEE, 1'b0, LAT + 4, 1, 1'b0};
    vecs[2] = '{15'h7FFF, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 1'b1, 2,       0, 1'b0};
    vecs[3] = '{15'h0000, 1'b0, 1'b1, 32'h0,        32'h12345678, 32'h12345678, 1'b0, LAT + 4, 1, 1'b0};
    vecs[4] = '{15'h1234, 1'b0, 1'b0, 32'h0BADF00D, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0, LAT + 4, 1, 1'b1};
    vecs[5] = '{15'h0042, 1'b1, 1'b1, 32'h5EED5EED, 32'h0,        32'h5EED5EED, 1'b1, 2,       0, 1'b1};

    // Reset held two edges with a pending request
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = 15'h0555;
    m_clear = 1'b1; m_hit_before = 1'b1; m_hit_after = 1'b1;
    m_hit_data = 32'h13572468; m_fill_data = 32'h0;
    exp_hits = '0; exp_misses = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_wren", {31'd0, dp_wrEn}, 32'd0);
    chk("rst_was_hit", {31'd0, cpu_was_hit}, 32'd0);
    chk("rst_fill_err", {31'd0, fill_err}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", {17'd0, dp_address}, 32'd0);
    chk("rst_counts", {24'd0, hit_count, miss_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("rel_accept_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rel_accept_addr", {17'd0, dp_address}, 32'h0555);
    @(posedge clk); #1;
    exp_hits = sat(exp_hits);
    chk("rel_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("rel_rdata", cpu_rdata, 32'h13572468);
    chk("rel_hits", {28'd0, hit_count}, {28'd0, exp_hits});
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) do_req(vecs[i], i);

    // Reset in the third cycle of a miss
    m_clear = 1'b1; m_hit_before = 1'b0; m_hit_after = 1'b1;
    cpu_addr = 15'h0321; cpu_req = 1'b1;
    @(posedge clk); #1; cpu_req = 1'b0; m_clear = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    exp_hits = '0; exp_misses = '0;
    chk("mrst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("mrst_counts", {24'd0, hit_count, miss_count}, 32'd0);
    chk("mrst_fill_err", {31'd0, fill_err}, 32'd0);
    bad_rv = 0; bad_fill = 0;
    for (int k = 0; k < 12; k++) begin
      if (cpu_rvalid) bad_rv++;
      if (dp_wrEn) bad_fill++;
      @(posedge clk); #1;
    end
    chk("mrst_no_rvalid", bad_rv, 0);
    chk("mrst_no_fill", bad_fill, 0);

    // 20 back-to-back hits with the request held high and the address churning
    m_clear = 1'b1; m_hit_before = 1'b1; m_hit_data = 32'h0F0F0F0F;
    cpu_req = 1'b1; cpu_addr = 15'h0100; acc_addr = cpu_addr;
    nrv = 0; last_rv = 0; bad_gap = 0; bad_addr = 0; c = 0;
    while (nrv < 20 && c < 200) begin
      @(posedge clk); #1; c++;
      cpu_addr = 15'(c + 15'h0100);
      if (cpu_ready) acc_addr = cpu_addr;
      else if (dp_address !== acc_addr) bad_addr++;
      if (cpu_rvalid) begin
        if (nrv == 0 ? (c != 2) : (c - last_rv != 3)) bad_gap++;
        last_rv = c; nrv++;
      end
    end
    cpu_req = 1'b0;
    chk("sat_responses", nrv, 20);
    chk("sat_spacing", bad_gap, 0);
    chk("sat_ignored_addr", bad_addr, 0);
    chk("sat_hit_count", {28'd0, hit_count}, 32'd15);
    chk("sat_miss_count", {28'd0, miss_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
